// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: constants and types shared by the instruction-fetch stage.
//   - NOP encoding used for IF/ID bubbles (sll $0,$0,0)
//   - default reset PC
//   - fetch FSM state encodings FETCH / HOLD / DRAIN
//   - IF/ID register layout and the saturating-increment helper used by
//     the optional performance counters
package fetch_stage_pkg;

    localparam logic [31:0] NOP_ENCODING     = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// fetch_perf_counters: three saturating event counters for the fetch stage.
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   stall_evt               - cycle in which IF/ID is frozen
//   flush_evt               - cycle with a redirect
//   wait_evt                - cycle with an outstanding, unacknowledged fetch
//   stall_cycles, flush_count, mem_wait_cycles - counter values (registered)
module fetch_perf_counters
    import fetch_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_evt,
    input  logic        flush_evt,
    input  logic        wait_evt,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic [31:0] mem_wait_cycles
);

    logic [31:0] stall_r;
    logic [31:0] flush_r;
    logic [31:0] wait_r;

    // Count each event once per cycle, saturating at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_r <= 32'h0;
            flush_r <= 32'h0;
            wait_r  <= 32'h0;
        end else begin
            stall_r <= stall_evt ? sat_inc(stall_r) : stall_r;
            flush_r <= flush_evt ? sat_inc(flush_r) : flush_r;
            wait_r  <= wait_evt  ? sat_inc(wait_r)  : wait_r;
        end
    end

    assign stall_cycles    = stall_r;
    assign flush_count     = flush_r;
    assign mem_wait_cycles = wait_r;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage. Owns the PC, issues one
// outstanding instruction-memory request at a time, and loads the IF/ID
// register. A one-entry hold buffer keeps a word returned during a stall.
// Optional feature macro: FETCH_PERF_EN adds three saturating perf counters.
// Ports:
//   clock, reset             - rising-edge clock, synchronous active-high reset
//   PCWrite, IFID_Write      - hazard-unit enables; fetch advances only if both 1
//   redirect, redirect_pc    - taken branch / jump target; flushes IF/ID
//   imem_req, imem_addr      - fetch request, held until imem_ack
//   imem_ack, imem_rdata     - memory response
//   IFID_instr, IFID_PC4, IFID_valid - IF/ID pipeline register
//   stall_cycles, flush_count, mem_wait_cycles - perf counters (FETCH_PERF_EN)
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IFID_Write,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IFID_instr,
    output logic [31:0] IFID_PC4,
`ifdef FETCH_PERF_EN
    output logic        IFID_valid,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic [31:0] mem_wait_cycles
`else
    output logic        IFID_valid
`endif
);

    fetch_state_t state_r;
    logic [31:0]  pc_r;
    logic [31:0]  target_r;
    logic [31:0]  hold_buf_r;
    logic         req_r;
    ifid_t        ifid_r;

    logic         advance_s;
    logic [31:0]  pc_plus4_s;
    ifid_t        bubble_s;

    // Mismatched enables from the hazard unit are treated as a stall.
    assign advance_s  = PCWrite & IFID_Write;
    assign pc_plus4_s = pc_r + 32'd4;
    assign bubble_s   = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

    // Fetch FSM: PC, request, hold buffer, redirect target and IF/ID register.
    // The PC is not updated while a request is outstanding, so it doubles as
    // the stable request address in FETCH and DRAIN.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_PC;
            target_r   <= 32'h0;
            hold_buf_r <= 32'h0;
            req_r      <= 1'b1;
            ifid_r     <= bubble_s;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            pc_r   <= redirect_pc;
                            ifid_r <= bubble_s;
                        end else if (advance_s) begin
                            pc_r   <= pc_plus4_s;
                            ifid_r <= '{instr: imem_rdata, pc4: pc_plus4_s, valid: 1'b1};
                        end else begin
                            hold_buf_r <= imem_rdata;
                            state_r    <= ST_HOLD;
                            req_r      <= 1'b0;
                        end
                    end else if (redirect) begin
                        // Request already issued cannot be withdrawn; park the target.
                        target_r <= redirect_pc;
                        ifid_r   <= bubble_s;
                        state_r  <= ST_DRAIN;
                    end else if (IFID_Write) begin
                        ifid_r <= bubble_s;
                    end else begin
                        ifid_r <= ifid_r;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        pc_r    <= redirect_pc;
                        ifid_r  <= bubble_s;
                        state_r <= ST_FETCH;
                        req_r   <= 1'b1;
                    end else if (advance_s) begin
                        pc_r    <= pc_plus4_s;
                        ifid_r  <= '{instr: hold_buf_r, pc4: pc_plus4_s, valid: 1'b1};
                        state_r <= ST_FETCH;
                        req_r   <= 1'b1;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    if (redirect || IFID_Write) begin
                        ifid_r <= bubble_s;
                    end else begin
                        ifid_r <= ifid_r;
                    end
                    if (redirect) begin
                        target_r <= redirect_pc;
                    end else begin
                        target_r <= target_r;
                    end
                    if (imem_ack) begin
                        pc_r    <= redirect ? redirect_pc : target_r;
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r <= ST_FETCH;
                    req_r   <= 1'b1;
                    ifid_r  <= bubble_s;
                end
            endcase
        end
    end

    assign imem_req   = req_r;
    assign imem_addr  = {pc_r[31:2], 2'b00};
    assign IFID_instr = ifid_r.instr;
    assign IFID_PC4   = ifid_r.pc4;
    assign IFID_valid = ifid_r.valid;

`ifdef FETCH_PERF_EN
    fetch_perf_counters u_perf (
        .clock           (clock),
        .reset           (reset),
        .stall_evt       (~IFID_Write),
        .flush_evt       (redirect),
        .wait_evt        (req_r & ~imem_ack),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .mem_wait_cycles (mem_wait_cycles)
    );
`endif

endmodule
